serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor computing D = A − B − Bin, one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the subtraction counterpart of the combinational ripple adder. It trades SIZE cycles of latency for one cell of logic. Operands enter and results leave over valid/ready handshakes, so it drops into any streaming datapath in the design.

## Interface
- SIZE, default 4: operand and result width in bits; legal range ≥ 2.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands A, B, Bin present.
- in_ready  out  1  block can accept operands.
- A  in  SIZE  minuend, unsigned.
- B  in  SIZE  subtrahend, unsigned.
- Bin  in  1  borrow in.
- out_valid  out  1  result D, Bout, zero valid.
- out_ready  in  1  consumer accepts result.
- D  out  SIZE  difference, (A − B − Bin) mod 2^SIZE.
- Bout  out  1  final borrow; 1 iff A < B + Bin.
- zero  out  1  1 iff out_valid and D == 0.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: capture A and B into shift registers a_sr and b_sr. Load borrow register br ← Bin. Clear cnt. Go to SHIFT.
- SHIFT, every cycle:
  - Cell inputs: a = a_sr[0], b = b_sr[0], bin = br.
  - d = a ^ b ^ bin.
  - bout = (~a & b) | (~a & bin) | (b & bin).
  - d_sr ← {d, d_sr[SIZE-1:1]}; a_sr and b_sr shift right by one; br ← bout; cnt ← cnt + 1.
  - When cnt == SIZE−1, go to DONE.
- DONE:
  - out_valid = 1. D = d_sr, Bout = br, zero = (d_sr == 0).
  - Outputs are held stable until out_ready. On out_valid & out_ready, go to IDLE.
- in_ready is 0 in SHIFT and DONE. in_valid in those states is ignored and its operands are not queued.
- A, B and Bin are sampled only at the input handshake edge. Changes on them during SHIFT or DONE have no effect.
- Arithmetic is unsigned modulo 2^SIZE. Bout is the only overflow indication. There is no signed interpretation.
- Reset values: state IDLE, in_ready 1, out_valid 0, D 0, Bout 0, zero 0, cnt 0, all shift registers 0.
- Reset mid-operation, in SHIFT or DONE, aborts the operation and discards the result. The block is in IDLE on the next cycle.
- rst has priority over every handshake in the same cycle.

## Timing
- Input handshake at edge E0. SHIFT occupies edges E1..E_SIZE.
- out_valid rises after E_SIZE, i.e. exactly SIZE cycles after acceptance.
- Output handshake at edge Ek returns the block to IDLE. in_ready is 1 in the following cycle.
- Minimum issue interval is SIZE+2 cycles, with out_ready held high.
- in_ready and out_valid are decoded from the registered state. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Package serial_sub_pkg holds:
  - typedef state_t enum {IDLE, SHIFT, DONE}, 2-bit encoding.
  - a function computing the counter width, $clog2(SIZE) with a minimum of 1.
- Sub-module full_subtractor: ports a, b, bin in; d, bout out. It is purely combinational and instantiated once.
- Top level holds the FSM, cnt, a_sr, b_sr, d_sr and br.

## Test plan
- SIZE=4, A=9, B=3, Bin=0 → D=6, Bout=0, zero=0; out_valid exactly 4 cycles after the input handshake.
- A=3, B=9, Bin=0 → D=10, Bout=1. Then A=0, B=0, Bin=1 → D=15, Bout=1.
- A=5, B=5, Bin=0 → D=0, Bout=0, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles while driving in_valid=1 with new operands. Required:
  - D, Bout and zero stay constant; in_ready stays 0; the new operands are not captured.
  - After out_ready rises, in_ready=1 on the next cycle.
- Assert rst during the 2nd SHIFT cycle. Required:
  - Next cycle: in_ready=1, out_valid=0, D=0.
  - A following op with A=12, B=7 yields D=5, Bout=0.
- SIZE=4, exhaustive: all 512 combinations of A, B and Bin, with random out_ready stalls. D and Bout must match the model A − B − Bin mod 16 and borrow = (A < B + Bin). Repeat a random subset with SIZE=8.

Source files
------------

// File: rtl/serial_sub_pkg.sv
`default_nettype none
// serial_sub_pkg: FSM state encoding and counter sizing helper for serial_subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit count index width; never narrower than one bit.
  function automatic int cnt_width(input int size);
    int w;
    w = $clog2(size);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// full_subtractor: one-bit combinational difference/borrow cell.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// serial_subtractor: bit-serial D = A - B - Bin, LSB first, one full-subtractor cell
// with a registered borrow, valid/ready on both sides.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            Bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] D,
  output logic            Bout,
  output logic            zero
);

  localparam int CNT_W = cnt_width(SIZE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);

  state_t          state;
  state_t          state_next;
  logic [SIZE-1:0] a_sr;
  logic [SIZE-1:0] b_sr;
  logic [SIZE-1:0] d_sr;
  logic            br;
  logic [CNT_W-1:0] cnt;
  logic            cell_d;
  logic            cell_bout;
  logic            accept;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      d_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_sr <= A;
        b_sr <= B;
        br   <= Bin;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        // Difference bits enter at the MSB so the LSB-first result lands aligned.
        d_sr <= {cell_d, d_sr[SIZE-1:1]};
        a_sr <= {1'b0, a_sr[SIZE-1:1]};
        b_sr <= {1'b0, b_sr[SIZE-1:1]};
        br   <= cell_bout;
        cnt  <= cnt + 1'b1;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign D         = out_valid ? d_sr : '0;
  assign Bout      = out_valid & br;
  assign zero      = out_valid & (d_sr == '0);

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// tb_serial_subtractor: directed + exhaustive (SIZE=4) and random (SIZE=8) checks
// against a cycle-level behavioural model of the handshake and arithmetic.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       v4, r4, ov4, ordy4, bin4, bout4, z4;
  logic [3:0] a4, b4, d4;
  logic       v8, r8, ov8, ordy8, bin8, bout8, z8;
  logic [7:0] a8, b8, d8;

  serial_subtractor #(.SIZE(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .A(a4), .B(b4), .Bin(bin4),
    .out_valid(ov4), .out_ready(ordy4), .D(d4), .Bout(bout4), .zero(z4)
  );

  serial_subtractor #(.SIZE(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .A(a8), .B(b8), .Bin(bin8),
    .out_valid(ov8), .out_ready(ordy8), .D(d8), .Bout(bout8), .zero(z8)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;
  bit rand_stall = 0;

  // Model: {borrow, difference mod 2^size} from plain integer arithmetic.
  function automatic logic [8:0] model(input int a, input int b, input int bin, input int size);
    int diff;
    int dm;
    diff = a - b - bin;
    dm   = (diff + 1024) % (1 << size);
    return {(a < b + bin), 8'(dm)};
  endfunction

  // Per-channel transaction state: busy flag, edges since acceptance, expected results.
  bit         pend4, pend8;
  int         since4, since8;
  logic [8:0] q4[$];
  logic [8:0] q8[$];

  always @(posedge clk) begin
    if (rst) begin
      pend4 = 0; since4 = 0; q4.delete(); started = 1;
    end else if (!pend4) begin
      if (v4) begin
        pend4 = 1; since4 = 0; q4.push_back(model(a4, b4, bin4, 4));
      end
    end else if (since4 >= 4 && ordy4) begin
      pend4 = 0; void'(q4.pop_front());
    end else begin
      since4++;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      pend8 = 0; since8 = 0; q8.delete();
    end else if (!pend8) begin
      if (v8) begin
        pend8 = 1; since8 = 0; q8.push_back(model(a8, b8, bin8, 8));
      end
    end else if (since8 >= 8 && ordy8) begin
      pend8 = 0; void'(q8.pop_front());
    end else begin
      since8++;
    end
  end

  always @(negedge clk) begin
    logic       eov;
    logic [8:0] e;
    if (started) begin
      eov = pend4 && since4 >= 4;
      e   = eov ? q4[0] : 9'd0;
      n_cmp++;
      if (r4 !== !pend4 || ov4 !== eov ||
          (eov && (d4 !== e[3:0] || bout4 !== e[8] || z4 !== (e[3:0] == 4'd0))) ||
          (!eov && z4 !== 1'b0)) begin
        n_bad++;
        $display("FAIL cyc4 t=%0t got rdy=%b ov=%b D=%0d Bout=%b z=%b exp rdy=%b ov=%b D=%0d Bout=%b",
                 $time, r4, ov4, d4, bout4, z4, !pend4, eov, e[3:0], e[8]);
      end
      eov = pend8 && since8 >= 8;
      e   = eov ? q8[0] : 9'd0;
      n_cmp++;
      if (r8 !== !pend8 || ov8 !== eov ||
          (eov && (d8 !== e[7:0] || bout8 !== e[8] || z8 !== (e[7:0] == 8'd0))) ||
          (!eov && z8 !== 1'b0)) begin
        n_bad++;
        $display("FAIL cyc8 t=%0t got rdy=%b ov=%b D=%0d Bout=%b z=%b exp rdy=%b ov=%b D=%0d Bout=%b",
                 $time, r8, ov8, d8, bout8, z8, !pend8, eov, e[7:0], e[8]);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rand_stall) begin
      ordy4 = ($urandom_range(0, 2) != 0);
      ordy8 = ($urandom_range(0, 2) != 0);
    end
  endtask

  // Returns at the negedge just after the acceptance edge.
  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic bn);
    int n;
    tick();
    a4 = a; b4 = b; bin4 = bn; v4 = 1'b1;
    n = 0;
    while (!r4 && n < 100) begin tick(); n++; end
    if (n >= 100) check("send4_timeout", 0, 1);
    tick();
    v4 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic bn);
    int n;
    tick();
    a8 = a; b8 = b; bin8 = bn; v8 = 1'b1;
    n = 0;
    while (!r8 && n < 100) begin tick(); n++; end
    if (n >= 100) check("send8_timeout", 0, 1);
    tick();
    v8 = 1'b0;
  endtask

  task automatic wait_ov4(output int n);
    n = 0;
    while (!ov4 && n < 100) begin tick(); n++; end
    if (n >= 100) check("ov4_timeout", 0, 1);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bn,
                     input int ed, input int eb, input int ez);
    int n;
    send4(a, b, bn);
    wait_ov4(n);
    check("latency", n, 4);
    check("D", d4, ed);
    check("Bout", bout4, eb);
    check("zero", z4, ez);
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    v4 = 0; a4 = 0; b4 = 0; bin4 = 0; ordy4 = 1;
    v8 = 0; a8 = 0; b8 = 0; bin8 = 0; ordy8 = 1;
    repeat (3) tick();
    check("rst_in_ready", r4, 1);
    check("rst_out_valid", ov4, 0);
    check("rst_D", d4, 0);
    check("rst_zero", z4, 0);
    rst = 1'b0;
    tick();

    op4(4'd9, 4'd3, 1'b0, 6, 0, 0);
    op4(4'd3, 4'd9, 1'b0, 10, 1, 0);
    op4(4'd0, 4'd0, 1'b1, 15, 1, 0);
    op4(4'd5, 4'd5, 1'b0, 0, 0, 1);

    // Backpressure: result must hold while new operands are offered and ignored.
    ordy4 = 1'b0;
    send4(4'd9, 4'd3, 1'b0);
    wait_ov4(n);
    for (int i = 0; i < 5; i++) begin
      tick();
      a4 = 4'd1; b4 = 4'd2; bin4 = 1'b1; v4 = 1'b1;
      check("bp_D", d4, 6);
      check("bp_Bout", bout4, 0);
      check("bp_zero", z4, 0);
      check("bp_in_ready", r4, 0);
    end
    ordy4 = 1'b1;
    v4 = 1'b0;
    tick();
    check("bp_release_in_ready", r4, 1);
    check("bp_release_out_valid", ov4, 0);

    // Reset during the second SHIFT cycle.
    send4(4'd9, 4'd3, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", r4, 1);
    check("abort_out_valid", ov4, 0);
    check("abort_D", d4, 0);
    op4(4'd12, 4'd7, 1'b0, 5, 0, 0);

    rand_stall = 1;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          send4(4'(a), 4'(b), 1'(c));

    for (int i = 0; i < 200; i++)
      send8(8'($urandom), 8'($urandom), 1'($urandom));
    send8(8'd0, 8'd255, 1'b1);
    send8(8'd255, 8'd255, 1'b0);

    n = 0;
    while ((!r4 || !r8) && n < 200) begin tick(); n++; end
    if (n >= 200) check("drain_timeout", 0, 1);
    rand_stall = 0;
    ordy4 = 1; ordy8 = 1;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
